// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register file.
//
// Takes the EX/WB pipeline register outputs (regWrite, Rd, ALU result) and
// commits them into a 2**ADDR_W x DATA_W register file. Two combinational
// read ports serve the decode stage. A saturating commit counter and
// last-write status are kept for debug visibility.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read port addressing the register being committed this
//                cycle returns wb_data directly (write-through forwarding)
//   undefined -> read ports return the stored array value only
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   wb_regWrite   in   write strobe from EX/WB
//   wb_Rd         in   destination index from EX/WB
//   wb_data       in   ALU result from EX/WB
//   rs_addr       in   read port A index
//   rt_addr       in   read port B index
//   rs_data       out  read port A data (combinational)
//   rt_data       out  read port B data (combinational)
//   commit_count  out  committed writes since reset, saturating
//   last_Rd       out  index of the most recent committed write
//   last_valid    out  high once any write has committed since reset
module wb_regfile #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int R0_ZERO = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_regWrite,
    input  logic [ADDR_W-1:0] wb_Rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [CNT_W-1:0]  commit_count,
    output logic [ADDR_W-1:0] last_Rd,
    output logic              last_valid
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NUM_RD = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DEPTH-1:0][DATA_W-1:0] file_q, file_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [ADDR_W-1:0]            last_rd_q, last_rd_d;
    logic                         last_valid_q, last_valid_d;
    logic                         commit;

    // regWrite gates everything, so X on wb_Rd/wb_data while regWrite=0
    // cannot reach any state element. Writes to R0 are dropped when it is
    // hardwired, so they neither touch the file nor count as commits.
    assign commit = wb_regWrite && !((R0_ZERO != 0) && (wb_Rd == '0));

    always_comb begin
        file_d       = file_q;
        cnt_d        = cnt_q;
        last_rd_d    = last_rd_q;
        last_valid_d = last_valid_q;
        if (commit) begin
            file_d[wb_Rd] = wb_data;
            last_rd_d     = wb_Rd;
            last_valid_d  = 1'b1;
            // hold at all-ones instead of wrapping
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            file_q       <= '0;
            cnt_q        <= '0;
            last_rd_q    <= '0;
            last_valid_q <= 1'b0;
        end else begin
            file_q       <= file_d;
            cnt_q        <= cnt_d;
            last_rd_q    <= last_rd_d;
            last_valid_q <= last_valid_d;
        end
    end

    // Read ports: port 0 = rs, port 1 = rt.
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

    assign rd_addr = {rt_addr, rs_addr};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        always_comb begin
            rd_data[p] = file_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            // forward the value being committed this cycle
            if (commit && (rd_addr[p] == wb_Rd)) begin
                rd_data[p] = wb_data;
            end
`endif
            // hardwired zero wins over the stored value and any bypass
            if ((R0_ZERO != 0) && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end
        end
    end

    assign rs_data      = rd_data[0];
    assign rt_data      = rd_data[1];
    assign commit_count = cnt_q;
    assign last_Rd      = last_rd_q;
    assign last_valid   = last_valid_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile (R0_ZERO=1, CNT_W=4 so
// counter saturation is reachable quickly). Expected values come from a
// plain array/integer model of the register file behaviour.
module tb_wb_regfile;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              wb_regWrite;
    logic [ADDR_W-1:0] wb_Rd;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [CNT_W-1:0]  commit_count;
    logic [ADDR_W-1:0] last_Rd;
    logic              last_valid;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ZERO(1), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .wb_regWrite(wb_regWrite), .wb_Rd(wb_Rd),
        .wb_data(wb_data), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
        .rt_data(rt_data), .commit_count(commit_count), .last_Rd(last_Rd),
        .last_valid(last_valid)
    );

    always #5 clock = ~clock;

    // reference model
    logic [DATA_W-1:0] m_file [8];
    int                m_cnt;
    logic [ADDR_W-1:0] m_last;
    logic              m_valid;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_file[i] = '0;
        m_cnt   = 0;
        m_last  = '0;
        m_valid = 1'b0;
    endtask

    // what a read port should show right now, given current inputs
    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wb_regWrite && wb_Rd == a) return wb_data;
`endif
        return m_file[a];
    endfunction

    // advance one clock; model follows the inputs sampled at the edge,
    // then returns on the following falling edge
    task automatic clk_step();
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else if (wb_regWrite && wb_Rd != 0) begin
            m_file[wb_Rd] = wb_data;
            m_last        = wb_Rd;
            m_valid       = 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        wb_regWrite = 1'b0;
        wb_Rd       = '0;
        wb_data     = '0;
    endtask

    task automatic test_reset();
        // a few writes first so reset has something to clear
        for (int i = 1; i < 8; i++) begin
            wb_regWrite = 1'b1; wb_Rd = i[2:0]; wb_data = 8'($urandom);
            clk_step();
        end
        idle_inputs();
        // mid low phase, no clock edge before the checks below
        #2 reset = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            rs_addr = 3'(2 * i); rt_addr = 3'(2 * i + 1);
            #0.5;
            checks++;
            if (rs_data !== 8'h00 || rt_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_read addr=%0d rs=%h rt=%h want 00", 2 * i, rs_data, rt_data);
            end
        end
        checks++;
        if (commit_count !== '0 || last_valid !== 1'b0 || last_Rd !== '0) begin
            errors++;
            $display("FAIL reset_status cnt=%0d valid=%b last=%0d want 0/0/0",
                     commit_count, last_valid, last_Rd);
        end
        @(negedge clock);
        // write presented while reset is held must be discarded
        wb_regWrite = 1'b1; wb_Rd = 3'd4; wb_data = 8'hEE;
        clk_step();
        rs_addr = 3'd4;
        #1;
        checks++;
        if (rs_data !== 8'h00 || commit_count !== '0 || last_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_write_wins rs=%h cnt=%0d valid=%b want 00/0/0",
                     rs_data, commit_count, last_valid);
        end
        idle_inputs();
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic_write();
        wb_regWrite = 1'b1; wb_Rd = 3'd3; wb_data = 8'hA5;
        clk_step();
        idle_inputs();
        rs_addr = 3'd3; rt_addr = 3'd3;
        #1;
        checks++;
        if (rs_data !== 8'hA5 || rt_data !== 8'hA5) begin
            errors++;
            $display("FAIL basic_read rs=%h rt=%h want a5", rs_data, rt_data);
        end
        checks++;
        if (commit_count !== 4'(m_cnt) || last_Rd !== 3'd3 || last_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_status cnt=%0d last=%0d valid=%b want %0d/3/1",
                     commit_count, last_Rd, last_valid, m_cnt);
        end
    endtask

    task automatic test_r0_drop();
        logic [CNT_W-1:0] cnt_before;
        logic             valid_before;
        cnt_before   = 4'(m_cnt);
        valid_before = m_valid;
        wb_regWrite = 1'b1; wb_Rd = 3'd0; wb_data = 8'hFF;
        rs_addr = 3'd0; rt_addr = 3'd0;
        #1;
        checks++;
        if (rs_data !== 8'h00 || rt_data !== 8'h00) begin
            errors++;
            $display("FAIL r0_same_cycle rs=%h rt=%h want 00", rs_data, rt_data);
        end
        clk_step();
        idle_inputs();
        #1;
        checks++;
        if (rs_data !== 8'h00 || commit_count !== cnt_before || last_valid !== valid_before) begin
            errors++;
            $display("FAIL r0_drop rs=%h cnt=%0d valid=%b want 00/%0d/%b",
                     rs_data, commit_count, last_valid, cnt_before, valid_before);
        end
    endtask

    task automatic test_bypass();
        wb_regWrite = 1'b1; wb_Rd = 3'd5; wb_data = 8'h11;
        clk_step();
        wb_regWrite = 1'b1; wb_Rd = 3'd5; wb_data = 8'h3C;
        rs_addr = 3'd5; rt_addr = 3'd1;
        #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (rs_data !== 8'h3C) begin
            errors++;
            $display("FAIL bypass_same_cycle rs=%h want 3c", rs_data);
        end
`else
        if (rs_data !== 8'h11) begin
            errors++;
            $display("FAIL bypass_same_cycle rs=%h want 11", rs_data);
        end
`endif
        clk_step();
        idle_inputs();
        #1;
        checks++;
        if (rs_data !== 8'h3C) begin
            errors++;
            $display("FAIL bypass_next_cycle rs=%h want 3c", rs_data);
        end
    endtask

    task automatic test_no_write();
        logic [DATA_W-1:0] r2_before;
        logic [CNT_W-1:0]  cnt_before;
        r2_before  = m_file[2];
        cnt_before = 4'(m_cnt);
        wb_regWrite = 1'b0; wb_Rd = 3'd2; wb_data = 8'h77;
        clk_step();
        wb_Rd = 'x; wb_data = 'x;
        clk_step();
        idle_inputs();
        rs_addr = 3'd2;
        #1;
        checks++;
        if (rs_data !== r2_before || commit_count !== cnt_before) begin
            errors++;
            $display("FAIL no_write r2=%h cnt=%0d want %h/%0d",
                     rs_data, commit_count, r2_before, cnt_before);
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wb_regWrite = 1'b1;
            wb_Rd       = 3'($urandom_range(1, 7));
            wb_data     = 8'($urandom);
            clk_step();
            idle_inputs();
            rs_addr = m_last;
            #1;
            checks++;
            if (commit_count !== 4'(m_cnt) || rs_data !== m_file[m_last]) begin
                errors++;
                $display("FAIL saturation step=%0d cnt=%0d rd=%h want %0d/%h",
                         i, commit_count, rs_data, m_cnt, m_file[m_last]);
            end
        end
        checks++;
        if (commit_count !== 4'hF) begin
            errors++;
            $display("FAIL saturation_final cnt=%h want f", commit_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            wb_regWrite = ($urandom_range(0, 9) < 7);
            wb_Rd       = 3'($urandom);
            wb_data     = 8'($urandom);
            rs_addr     = ($urandom_range(0, 3) == 0) ? wb_Rd : 3'($urandom);
            rt_addr     = ($urandom_range(0, 3) == 0) ? wb_Rd : 3'($urandom);
            #1;
            checks++;
            if (rs_data !== exp_read(rs_addr) || rt_data !== exp_read(rt_addr)) begin
                errors++;
                $display("FAIL random_read i=%0d rs[%0d]=%h rt[%0d]=%h want %h/%h", i,
                         rs_addr, rs_data, rt_addr, rt_data, exp_read(rs_addr), exp_read(rt_addr));
            end
            clk_step();
            checks++;
            if (commit_count !== 4'(m_cnt) || last_Rd !== m_last || last_valid !== m_valid) begin
                errors++;
                $display("FAIL random_status i=%0d cnt=%0d last=%0d valid=%b want %0d/%0d/%b",
                         i, commit_count, last_Rd, last_valid, m_cnt, m_last, m_valid);
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        rs_addr = '0; rt_addr = '0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        rs_addr = 3'd3; rt_addr = 3'd6;
        #1;
        checks++;
        if (rs_data !== 8'h00 || rt_data !== 8'h00 || commit_count !== '0 ||
            last_Rd !== '0 || last_valid !== 1'b0) begin
            errors++;
            $display("FAIL power_on_reset rs=%h rt=%h cnt=%0d last=%0d valid=%b",
                     rs_data, rt_data, commit_count, last_Rd, last_valid);
        end
        reset = 1'b0;
        @(negedge clock);

        test_basic_write();
        test_r0_drop();
        test_bypass();
        test_no_write();
        test_reset();
        test_saturation();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
